// File: rtl/board_io_pkg.sv
// Shared constants and the seven-segment glyph table for the board I/O register block.
package board_io_pkg;

  localparam logic [2:0] ADDR_SW        = 3'd0;
  localparam logic [2:0] ADDR_KEY_STATE = 3'd1;
  localparam logic [2:0] ADDR_KEY_EDGE  = 3'd2;
  localparam logic [2:0] ADDR_LEDR      = 3'd3;
  localparam logic [2:0] ADDR_LEDG      = 3'd4;
  localparam logic [2:0] ADDR_HEX_VAL   = 3'd5;
  localparam logic [2:0] ADDR_HEX_BLANK = 3'd6;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 6 = g down to bit 0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/board_io_regs_key_debounce.sv
// Per-key synchroniser and debouncer; press_pulse marks the cycle the debounced state rises.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_raw,
  output logic pressed,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ    = (r_sync2 != r_stable);
  assign w_accept    = w_differ && (r_cnt == CNT_MAX);
  // Combinational so the edge register can capture on the same edge stable updates.
  assign press_pulse = w_accept && r_sync2;
  assign pressed     = r_stable;

  // Two-flop synchroniser on the inverted (active-high) key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~key_n_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter; saturates at CNT_MAX rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else if (w_differ) begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/board_io_regs.sv
// Avalon-MM register block for switches, keys, LEDs and hex digits.
// Optional key interrupt is built when BOARD_IO_IRQ_EN is defined.
module board_io_regs
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int NUM_KEY         = 2,
  parameter int NUM_LEDR        = 8,
  parameter int NUM_LEDG        = 8,
  parameter int NUM_HEX         = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic [NUM_SW-1:0]      sw_in,
  input  logic [NUM_KEY-1:0]     key_n_in,
  output logic [NUM_LEDR-1:0]    ledr_out,
  output logic [NUM_LEDG-1:0]    ledg_out,
  output logic [7*NUM_HEX-1:0]   hex_out,
  output logic                   irq
);

  logic [NUM_SW-1:0]    r_sw_meta;
  logic [NUM_SW-1:0]    r_sw_sync;
  logic [NUM_KEY-1:0]   r_key_edge;
  logic [4*NUM_HEX-1:0] r_hex_val;
  logic [NUM_HEX-1:0]   r_hex_blank;
  logic [NUM_KEY-1:0]   w_key_state;
  logic [NUM_KEY-1:0]   w_key_press;
  logic [NUM_KEY-1:0]   w_edge_clr;
  logic [31:0]          w_rdata;

  for (genvar gi = 0; gi < NUM_KEY; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .key_n_raw  (key_n_in[gi]),
      .pressed    (w_key_state[gi]),
      .press_pulse(w_key_press[gi])
    );
  end

  assign w_edge_clr = (write && (address == ADDR_KEY_EDGE)) ? writedata[NUM_KEY-1:0] : '0;

  // Switch synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Press-edge capture; a new edge beats a simultaneous W1C of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_edge <= '0;
    end else begin
      r_key_edge <= (r_key_edge & ~w_edge_clr) | w_key_press;
    end
  end

  // Writable LED and hex registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_out    <= '0;
      ledg_out    <= '0;
      r_hex_val   <= '0;
      r_hex_blank <= '1;
    end else if (write) begin
      case (address)
        ADDR_LEDR:      ledr_out    <= writedata[NUM_LEDR-1:0];
        ADDR_LEDG:      ledg_out    <= writedata[NUM_LEDG-1:0];
        ADDR_HEX_VAL:   r_hex_val   <= writedata[4*NUM_HEX-1:0];
        ADDR_HEX_BLANK: r_hex_blank <= writedata[NUM_HEX-1:0];
        default:        ledr_out    <= ledr_out;
      endcase
    end else begin
      ledr_out <= ledr_out;
    end
  end

  // Registered segment drive, one cycle behind the hex registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_out <= '1;
    end else begin
      for (int i = 0; i < NUM_HEX; i++) begin
        hex_out[7*i +: 7] <= r_hex_blank[i] ? SEG_BLANK : hex_to_seg(r_hex_val[4*i +: 4]);
      end
    end
  end

`ifdef BOARD_IO_IRQ_EN
  logic [NUM_KEY-1:0] r_irq_mask;

  // Interrupt mask register and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask <= '0;
      irq        <= 1'b0;
    end else begin
      if (write && (address == ADDR_IRQ_MASK)) begin
        r_irq_mask <= writedata[NUM_KEY-1:0];
      end else begin
        r_irq_mask <= r_irq_mask;
      end
      irq <= |(r_key_edge & r_irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux over current (pre-write) register contents.
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      ADDR_SW:        w_rdata = 32'(r_sw_sync);
      ADDR_KEY_STATE: w_rdata = 32'(w_key_state);
      ADDR_KEY_EDGE:  w_rdata = 32'(r_key_edge);
      ADDR_LEDR:      w_rdata = 32'(ledr_out);
      ADDR_LEDG:      w_rdata = 32'(ledg_out);
      ADDR_HEX_VAL:   w_rdata = 32'(r_hex_val);
      ADDR_HEX_BLANK: w_rdata = 32'(r_hex_blank);
`ifdef BOARD_IO_IRQ_EN
      ADDR_IRQ_MASK:  w_rdata = 32'(r_irq_mask);
`endif
      default:        w_rdata = 32'd0;
    endcase
  end

  // Read data holds until the next read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (read) begin
      readdata <= w_rdata;
    end else begin
      readdata <= readdata;
    end
  end

endmodule

// File: tb/tb_board_io_regs.sv
// Directed self-checking bench for board_io_regs with DEBOUNCE_CYCLES=4.
module tb_board_io_regs;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  sw_in;
  logic [1:0]  key_n_in;
  logic [7:0]  ledr_out;
  logic [7:0]  ledg_out;
  logic [13:0] hex_out;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  board_io_regs #(
    .NUM_SW(4), .NUM_KEY(2), .NUM_LEDR(8), .NUM_LEDG(8), .NUM_HEX(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .sw_in(sw_in), .key_n_in(key_n_in),
    .ledr_out(ledr_out), .ledg_out(ledg_out), .hex_out(hex_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    n_total++;
    if ({ledr_out, ledg_out, hex_out, irq, readdata} !== {8'h00, 8'h00, 14'h3FFF, 1'b0, 32'h0})
      $display("FAIL reset_outputs ledr=%h ledg=%h hex=%h irq=%b rd=%h", ledr_out, ledg_out, hex_out, irq, readdata);
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      exp = (a == 6) ? 32'h3 : 32'h0;
      n_total++;
      if (rd !== exp) $display("FAIL reset_read addr=%0d got=%h want=%h", a, rd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_switches();
    logic [31:0] rd;
    sw_in = 4'b1011;
    tick(3);
    bus_read(3'd0, rd);
    n_total++;
    if (rd !== 32'hB) $display("FAIL sw_read got=%h want=%h", rd, 32'hB);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [31:0] rd;
    key_n_in[0] = 1'b0;
    tick(3);
    key_n_in[0] = 1'b1;
    tick(10);
    bus_read(3'd1, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL bounce_state got=%h want=%h", rd, 32'h0);
    else n_pass++;
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL bounce_edge got=%h want=%h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_press();
    logic [31:0] rd;
    address = 3'd1; read = 1'b1;
    key_n_in[0] = 1'b0;
    // readdata after edge n shows the state held before edge n; stable rises at edge 6.
    for (int n = 1; n <= 7; n++) begin
      tick(1);
      if (n == 6) begin
        n_total++;
        if (readdata !== 32'h0) $display("FAIL press_early got=%h want=%h", readdata, 32'h0);
        else n_pass++;
      end
      if (n == 7) begin
        n_total++;
        if (readdata !== 32'h1) $display("FAIL press_state got=%h want=%h", readdata, 32'h1);
        else n_pass++;
      end
    end
    read = 1'b0;
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL press_edge got=%h want=%h", rd, 32'h1);
    else n_pass++;
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL press_w1c got=%h want=%h", rd, 32'h0);
    else n_pass++;
    key_n_in[0] = 1'b1;
    tick(10);
    bus_read(3'd1, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL release_state got=%h want=%h", rd, 32'h0);
    else n_pass++;
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL release_edge got=%h want=%h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    key_n_in[1] = 1'b0;
    tick(5);
    // W1C lands on edge 6, the same edge the press is accepted.
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h2) $display("FAIL race_set_wins got=%h want=%h", rd, 32'h2);
    else n_pass++;
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL race_clear_after got=%h want=%h", rd, 32'h0);
    else n_pass++;
    key_n_in[1] = 1'b1;
    tick(10);
  endtask

  task automatic test_leds();
    logic [31:0] rd;
    bus_write(3'd3, 32'h1A5);
    bus_write(3'd4, 32'h3C);
    n_total++;
    if ({ledr_out, ledg_out} !== 16'hA53C) $display("FAIL led_outputs got=%h want=%h", {ledr_out, ledg_out}, 16'hA53C);
    else n_pass++;
    bus_read(3'd3, rd);
    n_total++;
    if (rd !== 32'hA5) $display("FAIL ledr_read got=%h want=%h", rd, 32'hA5);
    else n_pass++;
    // Read and write in the same cycle returns the old value.
    address = 3'd4; writedata = 32'h5A; write = 1'b1; read = 1'b1;
    tick(1);
    write = 1'b0; read = 1'b0;
    n_total++;
    if (readdata !== 32'h3C || ledg_out !== 8'h5A)
      $display("FAIL rw_same_cycle rd=%h ledg=%h want rd=%h ledg=%h", readdata, ledg_out, 32'h3C, 8'h5A);
    else n_pass++;
    bus_write(3'd0, 32'hF);
    bus_read(3'd0, rd);
    n_total++;
    if (rd !== 32'hB) $display("FAIL ro_write_ignored got=%h want=%h", rd, 32'hB);
    else n_pass++;
  endtask

  task automatic test_hex();
    logic [31:0] rd;
    bus_write(3'd5, 32'hA5);
    bus_write(3'd6, 32'h0);
    tick(1);
    n_total++;
    if (hex_out !== {7'b0001000, 7'b0010010}) $display("FAIL hex_a5 got=%h want=%h", hex_out, {7'b0001000, 7'b0010010});
    else n_pass++;
    bus_write(3'd6, 32'h2);
    tick(1);
    n_total++;
    if (hex_out !== {7'h7F, 7'b0010010}) $display("FAIL hex_blank1 got=%h want=%h", hex_out, {7'h7F, 7'b0010010});
    else n_pass++;
    bus_write(3'd6, 32'h0);
    bus_write(3'd5, 32'h8F);
    tick(1);
    n_total++;
    if (hex_out !== {7'b0000000, 7'b0001110}) $display("FAIL hex_8f got=%h want=%h", hex_out, {7'b0000000, 7'b0001110});
    else n_pass++;
    bus_write(3'd5, 32'h03);
    tick(1);
    n_total++;
    if (hex_out !== {7'b1000000, 7'b0110000}) $display("FAIL hex_03 got=%h want=%h", hex_out, {7'b1000000, 7'b0110000});
    else n_pass++;
    bus_read(3'd5, rd);
    n_total++;
    if (rd !== 32'h03) $display("FAIL hex_val_read got=%h want=%h", rd, 32'h03);
    else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] rd;
`ifdef BOARD_IO_IRQ_EN
    bus_write(3'd7, 32'h1);
    bus_read(3'd7, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL irq_mask_read got=%h want=%h", rd, 32'h1);
    else n_pass++;
    key_n_in[0] = 1'b0;
    tick(6);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_at_edge got=%b want=%b", irq, 1'b0);
    else n_pass++;
    tick(1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_after_edge got=%b want=%b", irq, 1'b1);
    else n_pass++;
    bus_write(3'd2, 32'h1);
    tick(1);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_cleared got=%b want=%b", irq, 1'b0);
    else n_pass++;
    key_n_in[0] = 1'b1;
    tick(10);
    bus_write(3'd7, 32'h0);
    key_n_in[0] = 1'b0;
    tick(10);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_masked got=%b want=%b", irq, 1'b0);
    else n_pass++;
`else
    bus_write(3'd7, 32'h3);
    bus_read(3'd7, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL irq_mask_absent got=%h want=%h", rd, 32'h0);
    else n_pass++;
    key_n_in[0] = 1'b0;
    tick(10);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_tied_low got=%b want=%b", irq, 1'b0);
    else n_pass++;
`endif
    bus_read(3'd2, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL irq_edge_captured got=%h want=%h", rd, 32'h1);
    else n_pass++;
    bus_write(3'd2, 32'h1);
    key_n_in[0] = 1'b1;
    tick(10);
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    sw_in = 4'h0; key_n_in = 2'b11;
    tick(1);
    test_reset();
    test_switches();
    test_bounce();
    test_press();
    test_set_wins();
    test_leds();
    test_hex();
    test_irq();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
